camera_line_ctrl_module: RTL and testbench
==========================================

CAMERA_LINE_CTRL_MODULE -- requirements
Module: camera_line_ctrl_module

Interface
REQ-001 SHALL have parameter XSIZE, default 160: 36-bit words per line; must match the line buffer's XSIZE.
REQ-002 SHALL have parameter YSIZE, default 120: lines per frame.
REQ-003 SHALL have port clk, input, 1: sole clock.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port iVsync, input, 1: one-cycle frame-start pulse from capture.
REQ-006 SHALL have port iPixEn, input, 1: packed 36-bit capture word present this cycle.
REQ-007 SHALL have port iRdReq, input, 1: sink requests the next stored line.
REQ-008 SHALL have port iSinkReady, input, 1: sink accepts a word one cycle later.
REQ-009 SHALL have port oEn, output, 2: line-buffer enables; [1] write, [0] read.
REQ-010 SHALL have port oRdValid, output, 1: line-buffer oData holds a valid word this cycle.
REQ-011 SHALL have port oLineStart, output, 1: qualifies the first valid word of a line.
REQ-012 SHALL have port oLineLast, output, 1: qualifies the last valid word of a line.
REQ-013 SHALL have port oFrameDone, output, 1: one-cycle pulse after line YSIZE-1 has been read.
REQ-014 SHALL have port oDrop, output, 1: sticky; at least one line was dropped since the last iVsync.
REQ-015 SHALL have port oLineCnt, output, 7: index of the next line to read.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, READ and FLUSH.
REQ-017 SHALL keep internal counters wcnt and rcnt (0..XSIZE-1, wrapping XSIZE-1 -> 0) mirroring the line buffer's write and read addresses.
REQ-018 SHALL keep flag full (one complete line stored, not yet read) and flag dropline (current input line discarded).
REQ-019 SHALL, in IDLE, hold oEn=0 and ignore iPixEn and iRdReq.
REQ-020 SHALL, in WAIT or READ, advance wcnt on every iPixEn.
REQ-021 SHALL drive oEn[1]=iPixEn & ~dropline combinationally.
REQ-022 SHALL, on iPixEn with wcnt==0, set dropline=full.
REQ-023 SHALL set oDrop whenever dropline is set to 1.
REQ-024 SHALL set full when iPixEn arrives with wcnt==XSIZE-1 and dropline==0.
REQ-025 SHALL transition WAIT -> READ when iRdReq & full.
REQ-026 SHALL, in READ, drive oEn[0]=iSinkReady and advance rcnt on each such cycle.
REQ-027 SHALL, in READ, on the read with rcnt==XSIZE-1, clear full, increment oLineCnt and return to WAIT.
REQ-028 SHALL, when the completed line has oLineCnt==YSIZE-1, pulse oFrameDone, zero oLineCnt and enter IDLE.
REQ-029 SHALL clear full at the end of READ even when a write completes a line in the same cycle, then set full from that write: the set wins.
REQ-030 SHALL drive oRdValid, oLineStart and oLineLast as oEn[0], (rcnt==0) and (rcnt==XSIZE-1) registered by one cycle, all forced 0 in FLUSH.
REQ-031 SHALL, on iVsync in IDLE or WAIT with wcnt==0 and rcnt==0, clear full, dropline, oDrop and oLineCnt and enter WAIT.
REQ-032 SHALL, on iVsync with wcnt!=0 or rcnt!=0, or in READ, enter FLUSH.
REQ-033 SHALL, in FLUSH, assert oEn[1] each cycle until wcnt==0 and oEn[0] each cycle until rcnt==0, independent of iPixEn and iSinkReady.
REQ-034 SHALL, in FLUSH, leave the buffer data undefined, ignore iPixEn, then clear full, dropline, oDrop and oLineCnt and enter WAIT.
REQ-035 SHALL register every output except oEn.

Reset
REQ-036 SHALL, on rst, force state IDLE; wcnt, rcnt, full, dropline, oLineCnt, oRdValid, oLineStart, oLineLast, oFrameDone, oDrop =0; oEn=0 in that same cycle.
REQ-037 SHALL have rst override iVsync and every other input.
REQ-038 SHALL require the line buffer's reset to be asserted concurrently with rst; a mid-line rst otherwise misaligns the buffer's counters.

Verification
REQ-039 Vsync, 160 iPixEn, iRdReq with iSinkReady=1 -> 160 oRdValid; oLineStart on word 0, oLineLast on word 159; oLineCnt 0->1.
REQ-040 Two full lines written with no iRdReq -> second line oEn[1]=0 throughout, oDrop=1; a later read returns line 0 data.
REQ-041 iSinkReady toggling 1/0 during READ -> oEn[0] mirrors it; exactly 160 oRdValid over 319 cycles; addresses stay contiguous.
REQ-042 iVsync after 37 written words and 0 reads -> FLUSH issues 123 oEn[1], no oRdValid, then WAIT; the next line reads back aligned at word 0.
REQ-043 YSIZE=2, two lines written and read -> oFrameDone pulses once after line 1's last read; FSM enters IDLE and ignores iPixEn.
REQ-044 rst asserted in READ at rcnt=80 -> all outputs 0 the next cycle; FSM in IDLE.

Source files
------------

// File: rtl/camera_line_ctrl_module.sv
// Control FSM for a single-line capture buffer: gates writes and reads, keeps counters
// aligned with the buffer's internal addresses and flushes them back to zero on a frame start.
module camera_line_ctrl_module #(
  parameter int unsigned XSIZE = 160,
  parameter int unsigned YSIZE = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iVsync,
  input  logic       iPixEn,
  input  logic       iRdReq,
  input  logic       iSinkReady,
  output logic [1:0] oEn,
  output logic       oRdValid,
  output logic       oLineStart,
  output logic       oLineLast,
  output logic       oFrameDone,
  output logic       oDrop,
  output logic [6:0] oLineCnt
);

  localparam int unsigned CW = (XSIZE > 1) ? $clog2(XSIZE) : 1;
  localparam logic [CW-1:0] XLAST = CW'(XSIZE - 1);
  localparam logic [6:0]    YLAST = 7'(YSIZE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          full_q, full_d;
  logic          drop_q, drop_d;
  logic          odrop_q, odrop_d;
  logic [6:0]    linecnt_q, linecnt_d;
  logic          rdvalid_q, rdvalid_d;
  logic          lstart_q, lstart_d;
  logic          llast_q, llast_d;
  logic          fdone_q, fdone_d;
  logic [1:0]    en;
  logic          drop_now;
  logic          full_set, full_clr;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    drop_d    = drop_q;
    odrop_d   = odrop_q;
    linecnt_d = linecnt_q;
    fdone_d   = 1'b0;
    full_set  = 1'b0;
    full_clr  = 1'b0;
    en        = '0;
    // The first word of a line already sees the drop decision it triggers.
    drop_now  = (wcnt_q == '0) ? full_q : drop_q;

    case (state_q)
      S_WAIT, S_READ: begin
        en[1] = iPixEn & ~drop_now;
        en[0] = (state_q == S_READ) ? iSinkReady : 1'b0;
        if (iPixEn) begin
          wcnt_d = (wcnt_q == XLAST) ? '0 : wcnt_q + CW'(1);
          if (wcnt_q == '0) begin
            drop_d = full_q;
            if (full_q) odrop_d = 1'b1;
          end
          if (wcnt_q == XLAST && !drop_now) full_set = 1'b1;
        end
      end
      S_FLUSH: begin
        en[1] = (wcnt_q != '0);
        en[0] = (rcnt_q != '0);
        if (en[1]) wcnt_d = (wcnt_q == XLAST) ? '0 : wcnt_q + CW'(1);
      end
      default: ;
    endcase

    if (en[0]) rcnt_d = (rcnt_q == XLAST) ? '0 : rcnt_q + CW'(1);

    case (state_q)
      S_WAIT: if (iRdReq && full_q) state_d = S_READ;
      S_READ: begin
        if (en[0] && rcnt_q == XLAST) begin
          full_clr = 1'b1;
          if (linecnt_q == YLAST) begin
            fdone_d   = 1'b1;
            linecnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            linecnt_d = linecnt_q + 7'd1;
            state_d   = S_WAIT;
          end
        end
      end
      default: ;
    endcase

    full_d = (full_q & ~full_clr) | full_set;

    if (state_q == S_FLUSH) begin
      if (wcnt_q == '0 && rcnt_q == '0) begin
        full_d    = 1'b0;
        drop_d    = 1'b0;
        odrop_d   = 1'b0;
        linecnt_d = '0;
        state_d   = S_WAIT;
      end
    end else if (iVsync) begin
      if (state_q != S_READ && wcnt_q == '0 && rcnt_q == '0) begin
        full_d    = 1'b0;
        drop_d    = 1'b0;
        odrop_d   = 1'b0;
        linecnt_d = '0;
        state_d   = S_WAIT;
      end else begin
        state_d = S_FLUSH;
      end
    end

    rdvalid_d = en[0] & (state_q != S_FLUSH);
    lstart_d  = rdvalid_d & (rcnt_q == '0);
    llast_d   = rdvalid_d & (rcnt_q == XLAST);

    if (rst) en = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      full_q    <= 1'b0;
      drop_q    <= 1'b0;
      odrop_q   <= 1'b0;
      linecnt_q <= '0;
      rdvalid_q <= 1'b0;
      lstart_q  <= 1'b0;
      llast_q   <= 1'b0;
      fdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      full_q    <= full_d;
      drop_q    <= drop_d;
      odrop_q   <= odrop_d;
      linecnt_q <= linecnt_d;
      rdvalid_q <= rdvalid_d;
      lstart_q  <= lstart_d;
      llast_q   <= llast_d;
      fdone_q   <= fdone_d;
    end
  end

  assign oEn        = en;
  assign oRdValid   = rdvalid_q;
  assign oLineStart = lstart_q;
  assign oLineLast  = llast_q;
  assign oFrameDone = fdone_q;
  assign oDrop      = odrop_q;
  assign oLineCnt   = linecnt_q;

endmodule

// File: tb/tb_camera_line_ctrl_module.sv
// Scoreboard bench: a behavioural line buffer driven by oEn supplies read data,
// expected words are queued when a read is requested and popped on oRdValid.
module tb_camera_line_ctrl_module;

  localparam int unsigned XS = 160;

  logic       clk = 1'b0;
  logic       rst, iVsync, iPixEn, iRdReq, iSinkReady;
  logic [1:0] oEn;
  logic       oRdValid, oLineStart, oLineLast, oFrameDone, oDrop;
  logic [6:0] oLineCnt;

  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  int nfdone = 0;

  typedef struct {
    logic [35:0] d;
    logic        s;
    logic        l;
  } exp_t;
  exp_t sbq[$];

  logic [35:0] mem [XS];
  logic [35:0] pix, bdata;
  int unsigned bw, br;

  always #5 clk = ~clk;

  camera_line_ctrl_module #(.XSIZE(XS), .YSIZE(2)) dut (
    .clk(clk), .rst(rst), .iVsync(iVsync), .iPixEn(iPixEn), .iRdReq(iRdReq),
    .iSinkReady(iSinkReady), .oEn(oEn), .oRdValid(oRdValid), .oLineStart(oLineStart),
    .oLineLast(oLineLast), .oFrameDone(oFrameDone), .oDrop(oDrop), .oLineCnt(oLineCnt)
  );

  // Line buffer model: own address counters, reset together with the controller.
  always @(posedge clk) begin
    if (rst) begin
      bw    <= 0;
      br    <= 0;
      bdata <= '0;
    end else begin
      if (oEn[1]) begin
        mem[bw] <= pix;
        bw      <= (bw == XS - 1) ? 0 : bw + 1;
      end
      if (oEn[0]) begin
        bdata <= mem[br];
        br    <= (br == XS - 1) ? 0 : br + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] pixval(input int tag, input int i);
    return {4'h0, tag[15:0], i[15:0]};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (oRdValid) begin
      nvalid++;
      if (sbq.size() == 0) begin
        check_eq("rd_unexpected", oRdValid, 0);
      end else begin
        e = sbq.pop_front();
        check_eq("rd_data", bdata, e.d);
        check_eq("rd_start", oLineStart, e.s);
        check_eq("rd_last", oLineLast, e.l);
      end
    end
    if (oFrameDone) nfdone++;
  end

  task automatic pulse_vsync();
    @(negedge clk) iVsync = 1'b1;
    @(negedge clk) iVsync = 1'b0;
  endtask

  task automatic write_words(input int tag, input int n, input logic exp_en);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      iPixEn = 1'b1;
      pix    = pixval(tag, i);
      #1 check_eq("wr_en", oEn[1], exp_en);
    end
    @(negedge clk) iPixEn = 1'b0;
  endtask

  // Returns at the negedge where the last requested read's data becomes visible.
  task automatic read_line(input int tag, input int nreads, input bit toggle);
    int cnt = 0;
    int k   = 0;
    for (int i = 0; i < nreads; i++) sbq.push_back('{pixval(tag, i), i == 0, i == XS - 1});
    @(negedge clk);
    iRdReq     = 1'b1;
    iSinkReady = 1'b1;
    #1 check_eq("rdreq_en0", oEn[0], 0);
    @(negedge clk) iRdReq = 1'b0;
    while (cnt < nreads) begin
      iSinkReady = toggle ? ((k % 2) == 0) : 1'b1;
      #1 check_eq("rd_en", oEn[0], iSinkReady);
      if (iSinkReady) cnt++;
      k++;
      @(negedge clk);
    end
  endtask

  task automatic finish_read();
    iSinkReady = 1'b1;
    #1 check_eq("rd_done_en0", oEn[0], 0);
    iSinkReady = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain", sbq.size(), 0);
  endtask

  initial begin
    int v0, nw, nr;
    rst = 1'b1; iVsync = 1'b0; iPixEn = 1'b0; iRdReq = 1'b0; iSinkReady = 1'b0; pix = '0;
    repeat (3) @(negedge clk);
    iPixEn = 1'b1; iSinkReady = 1'b1;
    #1 check_eq("rst_en", oEn, 0);
    check_eq("rst_valid", oRdValid, 0);
    check_eq("rst_fdone", oFrameDone, 0);
    check_eq("rst_drop", oDrop, 0);
    check_eq("rst_linecnt", oLineCnt, 0);
    @(negedge clk) rst = 1'b0; iPixEn = 1'b0; iSinkReady = 1'b0;

    // IDLE ignores pixels
    @(negedge clk) iPixEn = 1'b1;
    #1 check_eq("idle_en", oEn, 0);
    @(negedge clk) iPixEn = 1'b0;

    // Frame 1: basic line, then a toggling sink finishing the frame
    pulse_vsync();
    write_words(1, XS, 1'b1);
    v0 = nvalid;
    read_line(1, XS, 1'b0);
    finish_read();
    drain();
    check_eq("l0_nvalid", nvalid - v0, XS);
    check_eq("l0_linecnt", oLineCnt, 1);
    check_eq("l0_fdone", nfdone, 0);

    write_words(2, XS, 1'b1);
    v0 = nvalid;
    read_line(2, XS, 1'b1);
    finish_read();
    drain();
    check_eq("toggle_nvalid", nvalid - v0, XS);
    check_eq("frame_fdone", nfdone, 1);
    check_eq("frame_linecnt", oLineCnt, 0);
    repeat (5) begin
      @(negedge clk) iPixEn = 1'b1;
      #1 check_eq("post_frame_idle_en", oEn, 0);
    end
    @(negedge clk) iPixEn = 1'b0;

    // Frame 2: second line dropped while the first is unread
    pulse_vsync();
    write_words(3, XS, 1'b1);
    write_words(4, XS, 1'b0);
    check_eq("drop_flag", oDrop, 1);
    read_line(3, XS, 1'b0);
    finish_read();
    drain();
    check_eq("drop_linecnt", oLineCnt, 1);

    // Partial line then vsync forces a flush
    write_words(5, 37, 1'b1);
    pulse_vsync();
    nw = 0; nr = 0; v0 = nvalid;
    repeat (140) begin
      #1;
      if (oEn[1]) nw++;
      if (oEn[0]) nr++;
      @(negedge clk);
    end
    check_eq("flush_wr", nw, XS - 37);
    check_eq("flush_rd", nr, 0);
    check_eq("flush_valid", nvalid - v0, 0);
    check_eq("flush_drop", oDrop, 0);
    check_eq("flush_linecnt", oLineCnt, 0);
    write_words(6, XS, 1'b1);
    read_line(6, XS, 1'b0);
    finish_read();
    drain();
    check_eq("postflush_linecnt", oLineCnt, 1);

    // Reset in the middle of a read
    write_words(7, XS, 1'b1);
    read_line(7, 80, 1'b0);
    rst = 1'b1;
    #1 check_eq("midrst_en", oEn, 0);
    @(negedge clk);
    check_eq("midrst_en2", oEn, 0);
    check_eq("midrst_valid", oRdValid, 0);
    check_eq("midrst_start", oLineStart, 0);
    check_eq("midrst_last", oLineLast, 0);
    check_eq("midrst_fdone", oFrameDone, 0);
    check_eq("midrst_drop", oDrop, 0);
    check_eq("midrst_linecnt", oLineCnt, 0);
    rst = 1'b0; iSinkReady = 1'b0;
    @(negedge clk) iPixEn = 1'b1;
    #1 check_eq("postrst_idle_en", oEn, 0);
    @(negedge clk) iPixEn = 1'b0;

    pulse_vsync();
    write_words(8, XS, 1'b1);
    read_line(8, XS, 1'b0);
    finish_read();
    drain();
    check_eq("final_linecnt", oLineCnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
